pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage RISC-V pipeline (F/D/E/M/W). It resolves data hazards with E-stage forwarding selects. It inserts load-use bubbles and flushes the front end on taken branches and jumps resolved in E. It also freezes the pipeline while the data memory handshake in M is outstanding, and raises a sticky error if memory never answers.

---
 rtl/pipeline_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: forwarding, load-use, branch-flush and data-memory freeze control for the F/D/E/M/W pipeline.
// Define PIPELINE_CTRL_PERF_EN to add the stall_cycles / flush_events performance counters.
module pipeline_ctrl #(
  parameter int TIMEOUT = 16
`ifdef PIPELINE_CTRL_PERF_EN
  , parameter int PCNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic       load_e,
  input  logic       pcsrc_e,
  input  logic [4:0] rd_m,
  input  logic       regwrite_m,
  input  logic [4:0] rd_w,
  input  logic       regwrite_w,
  input  logic       dmem_req_m,
  input  logic       dmem_ready,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_w,
  output logic       mem_err
`ifdef PIPELINE_CTRL_PERF_EN
  , output logic [PCNT_W-1:0] stall_cycles
  , output logic [PCNT_W-1:0] flush_events
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mem_err_nxt;
  logic       lwstall, memstall;

  assign lwstall  = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign memstall = dmem_req_m && !dmem_ready;

  // M result is newer than W, so it wins when both target the same source register.
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (!rst) begin
      if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs1_e))      fwd_a_e = 2'b10;
      else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs1_e)) fwd_a_e = 2'b01;
      if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs2_e))      fwd_b_e = 2'b10;
      else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs2_e)) fwd_b_e = 2'b01;
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if ((state == ERR) || memstall) begin
      // Whole pipe frozen; a pending branch or load-use re-presents once E unfreezes.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pcsrc_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lwstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err;
    case (state)
      RUN: begin
        if (memstall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready || !dmem_req_m) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt + 8'd1 == TIMEOUT_CNT) begin
          state_nxt   = ERR;
          mem_err_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic branch_flush;
  assign branch_flush = !rst && (state != ERR) && !memstall && pcsrc_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (state != ERR) begin
      if (stall_f)      stall_cycles <= stall_cycles + PCNT_W'(1);
      if (branch_flush) flush_events <= flush_events + PCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed-vector bench for pipeline_ctrl with a queue-based scoreboard.
// Counter checks are compiled in when PIPELINE_CTRL_PERF_EN is defined.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic       load_e, pcsrc_e;
    logic [4:0] rd_m;
    logic       regwrite_m;
    logic [4:0] rd_w;
    logic       regwrite_w, dmem_req_m, dmem_ready;
  } stim_t;

  typedef struct {
    string       name;
    logic [11:0] ctl;
    bit          chkPerf;
    int          stallCnt;
    int          flushCnt;
  } exp_t;

  // Packed as {fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err}
  localparam logic [11:0] NONE     = 12'h000;
  localparam logic [11:0] RSTV     = 12'h00E;
  localparam logic [11:0] STALLALL = 12'h0F2;
  localparam logic [11:0] ERRV     = 12'h0F3;
  localparam logic [11:0] LWS      = 12'h0C4;
  localparam logic [11:0] BR       = 12'h00C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0, rd_e = '0, rd_m = '0, rd_w = '0;
  logic       load_e = 1'b0, pcsrc_e = 1'b0, regwrite_m = 1'b0, regwrite_w = 1'b0;
  logic       dmem_req_m = 1'b0, dmem_ready = 1'b0;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];

  always #5 clk = ~clk;

  pipeline_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .load_e(load_e), .pcsrc_e(pcsrc_e),
    .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .mem_err(mem_err)
`ifdef PIPELINE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input stim_t v);
    @(posedge clk);
    #1;
    rst        = v.rst;
    rs1_d      = v.rs1_d;
    rs2_d      = v.rs2_d;
    rs1_e      = v.rs1_e;
    rs2_e      = v.rs2_e;
    rd_e       = v.rd_e;
    load_e     = v.load_e;
    pcsrc_e    = v.pcsrc_e;
    rd_m       = v.rd_m;
    regwrite_m = v.regwrite_m;
    rd_w       = v.rd_w;
    regwrite_w = v.regwrite_w;
    dmem_req_m = v.dmem_req_m;
    dmem_ready = v.dmem_ready;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] ctl,
                             input bit chkPerf = 1'b0, input int sc = 0, input int fe = 0);
    exp_t e;
    e.name     = name;
    e.ctl      = ctl;
    e.chkPerf  = chkPerf;
    e.stallCnt = sc;
    e.flushCnt = fe;
    expQ.push_back(e);
  endtask

  // Monitor: every cycle that has a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e   = expQ.pop_front();
      act = {fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err};
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("[TB] FAIL %s: got %03h expected %03h", e.name, act, e.ctl);
      end
`ifdef PIPELINE_CTRL_PERF_EN
      if (e.chkPerf) begin
        checks++;
        if (stall_cycles !== 32'(e.stallCnt) || flush_events !== 32'(e.flushCnt)) begin
          failures++;
          $display("[TB] FAIL %s_counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   e.name, stall_cycles, flush_events, e.stallCnt, e.flushCnt);
        end
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t v;

    v = '0; v.rst = 1'b1; v.rd_m = 5'd5; v.regwrite_m = 1'b1; v.rs1_e = 5'd5;
    applyStimulus(v); checkOutput("reset", RSTV);

    v = '0; v.rd_m = 5'd5; v.rd_w = 5'd5; v.regwrite_m = 1'b1; v.regwrite_w = 1'b1; v.rs1_e = 5'd5;
    applyStimulus(v); checkOutput("fwd_m_priority", 12'h800);
    v.regwrite_m = 1'b0;
    applyStimulus(v); checkOutput("fwd_w", 12'h400);
    v.regwrite_m = 1'b1; v.rd_m = 5'd0; v.rd_w = 5'd0; v.rs1_e = 5'd0;
    applyStimulus(v); checkOutput("fwd_x0", NONE);
    v = '0; v.rd_m = 5'd5; v.regwrite_m = 1'b1; v.rs1_e = 5'd5;
    v.rd_w = 5'd3; v.regwrite_w = 1'b1; v.rs2_e = 5'd3;
    applyStimulus(v); checkOutput("fwd_a_m_b_w", 12'h900);

    v = '0; v.load_e = 1'b1; v.rd_e = 5'd7; v.rs2_d = 5'd7;
    applyStimulus(v); checkOutput("loaduse", LWS);
    v = '0; v.rs2_d = 5'd7;
    applyStimulus(v); checkOutput("loaduse_done", NONE);
    v = '0; v.load_e = 1'b1; v.rd_e = 5'd7; v.rs2_d = 5'd7; v.pcsrc_e = 1'b1;
    applyStimulus(v); checkOutput("loaduse_branch", BR);
    v = '0; v.load_e = 1'b1; v.rd_e = 5'd0; v.rs1_d = 5'd0;
    applyStimulus(v); checkOutput("loaduse_x0", NONE);

    for (int i = 0; i < 3; i++) begin
      v = '0; v.dmem_req_m = 1'b1; v.pcsrc_e = 1'b1;
      applyStimulus(v); checkOutput("memwait", STALLALL);
    end
    v = '0; v.dmem_req_m = 1'b1; v.dmem_ready = 1'b1; v.pcsrc_e = 1'b1;
    applyStimulus(v); checkOutput("memwait_ready_branch", BR);
    v = '0;
    applyStimulus(v); checkOutput("memwait_after", NONE);
    v = '0; v.dmem_req_m = 1'b1; v.dmem_ready = 1'b1;
    applyStimulus(v); checkOutput("single_cycle_mem", NONE);

    for (int i = 0; i < 15; i++) begin
      v = '0; v.dmem_req_m = 1'b1;
      applyStimulus(v); checkOutput("nearmiss_wait", STALLALL);
    end
    v = '0; v.dmem_req_m = 1'b1; v.dmem_ready = 1'b1;
    applyStimulus(v); checkOutput("nearmiss_ready", NONE);
    v = '0;
    applyStimulus(v); checkOutput("nearmiss_no_err", NONE);

    for (int i = 0; i < 16; i++) begin
      v = '0; v.dmem_req_m = 1'b1;
      applyStimulus(v); checkOutput("timeout_wait", STALLALL);
    end
    v = '0; v.dmem_req_m = 1'b1; v.dmem_ready = 1'b1;
    applyStimulus(v); checkOutput("err_after_ready", ERRV);
    v = '0; v.pcsrc_e = 1'b1;
    applyStimulus(v); checkOutput("err_sticky_branch", ERRV);
    v = '0; v.rst = 1'b1;
    applyStimulus(v); checkOutput("err_reset_cycle", RSTV | 12'h001);
    v = '0;
    applyStimulus(v); checkOutput("err_cleared", NONE);

    for (int i = 0; i < 5; i++) begin
      v = '0; v.dmem_req_m = 1'b1;
      applyStimulus(v); checkOutput("midwait", STALLALL);
    end
    v = '0; v.rst = 1'b1; v.dmem_req_m = 1'b1;
    applyStimulus(v); checkOutput("midwait_reset", RSTV);
    v = '0;
    applyStimulus(v); checkOutput("midwait_run", NONE);
    for (int i = 0; i < 15; i++) begin
      v = '0; v.dmem_req_m = 1'b1;
      applyStimulus(v); checkOutput("midwait_recount", STALLALL);
    end
    v = '0; v.dmem_req_m = 1'b1; v.dmem_ready = 1'b1;
    applyStimulus(v); checkOutput("midwait_recount_ready", NONE);

    v = '0; v.rst = 1'b1;
    applyStimulus(v); checkOutput("perf_reset", RSTV);
    for (int i = 0; i < 4; i++) begin
      v = '0; v.dmem_req_m = 1'b1;
      applyStimulus(v); checkOutput("perf_memstall", STALLALL);
    end
    v = '0; v.dmem_req_m = 1'b1; v.dmem_ready = 1'b1;
    applyStimulus(v); checkOutput("perf_ready", NONE);
    for (int i = 0; i < 2; i++) begin
      v = '0; v.pcsrc_e = 1'b1;
      applyStimulus(v); checkOutput("perf_branch", BR);
    end
    v = '0;
    applyStimulus(v); checkOutput("perf_idle", NONE, 1'b1, 4, 2);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
